autoscale_frame_ctrl: RTL

Frame-level gain controller for the autoscale stage ahead of the arctangent/FRB detection datapath. It measures the peak of the two unsigned inputs over each frame of FRAME_LEN valid samples and derives one common left-shift. That shift is applied to every sample of the following frame, with clamping, hysteresis and saturation. All samples in a frame therefore share one scale, and downstream logic receives the exponent aligned with the data.

---
 rtl/autoscale_frame_ctrl_if.sv | 27 ++
 rtl/autoscale_frame_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/autoscale_frame_ctrl_if.sv
// Sample stream into and scaled stream out of the autoscale frame controller.
// The DUT takes the slave view; a producer/consumer takes the master view.
interface autoscale_frame_ctrl_if #(
  parameter int DIN_WIDTH = 32,
  parameter int SW        = $clog2(DIN_WIDTH)
);
  logic [DIN_WIDTH-1:0] din1;
  logic [DIN_WIDTH-1:0] din2;
  logic                 din_valid;
  logic                 sync;
  logic [DIN_WIDTH-1:0] dout1;
  logic [DIN_WIDTH-1:0] dout2;
  logic                 dout_valid;
  logic                 dout_sof;
  logic [SW-1:0]        frame_shift;
  logic [15:0]          ovf_count;

  modport slave (
    input  din1, din2, din_valid, sync,
    output dout1, dout2, dout_valid, dout_sof, frame_shift, ovf_count
  );

  modport master (
    output din1, din2, din_valid, sync,
    input  dout1, dout2, dout_valid, dout_sof, frame_shift, ovf_count
  );
endinterface

// File: rtl/autoscale_frame_ctrl.sv
// Frame-level autoscale: measures each frame's peak and applies one common,
// hysteresis-filtered, saturating left shift to every sample of the next frame.
module autoscale_frame_ctrl #(
  parameter int DIN_WIDTH   = 32,
  parameter int FRAME_LEN   = 1024,
  parameter int MAX_SHIFT   = 10,
  parameter int MIN_SHIFT   = 3,
  parameter int HEADROOM    = 2,
  parameter int HOLD_FRAMES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  autoscale_frame_ctrl_if.slave bus
);

  localparam int SW = $clog2(DIN_WIDTH);
  localparam int CW = $clog2(FRAME_LEN);
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  function automatic logic [SW-1:0] lead_one(input logic [DIN_WIDTH-1:0] p);
    lead_one = '0;
    for (int i = 0; i < DIN_WIDTH; i++) begin
      if (p[i]) lead_one = SW'(i);
    end
  endfunction

  // Frame tracking state
  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DIN_WIDTH-1:0] peak_q, peak_d;
  logic [DIN_WIDTH-1:0] peak_lat_q, peak_lat_d;
  logic                 close_d, accept_d, sof_d;
  logic [DIN_WIDTH-1:0] sample_or;

  // Control pipeline
  logic                 close1_q, close2_q;
  logic [SW-1:0]        lead_q;
  logic                 pzero_q;
  int                   raw_shift;
  logic [SW-1:0]        cand;
  logic [SW-1:0]        applied_q, applied_d;
  logic [HW-1:0]        hold_q, hold_d;

  // Data pipeline
  logic                 v1_q, v2_q, v3_q, sof1_q, sof2_q, sof3_q;
  logic [DIN_WIDTH-1:0] a1_q, b1_q, a2_q, b2_q, a3_q, b3_q;
  logic [SW-1:0]        fs_lat_q, s3_q, s_cur;
  logic                 ovf3_q;
  logic [DIN_WIDTH-1:0] sh_a, sh_b, out_a, out_b;
  logic                 sat_a, sat_b;
  logic [DIN_WIDTH-1:0] dout1_q, dout2_q;
  logic                 dout_valid_q, dout_sof_q;
  logic [SW-1:0]        frame_shift_q;
  logic [15:0]          ovf_q;

  assign sample_or = bus.din1 | bus.din2;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    peak_d     = peak_q;
    peak_lat_d = peak_lat_q;
    close_d    = 1'b0;
    accept_d   = 1'b0;
    sof_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.din_valid && bus.sync) begin
          state_d  = S_RUN;
          accept_d = 1'b1;
          sof_d    = 1'b1;
          peak_d   = sample_or;
          cnt_d    = CW'(1);
        end
      end
      S_RUN: begin
        if (bus.din_valid) begin
          accept_d = 1'b1;
          if (bus.sync && cnt_q != '0) begin
            // Resync: drop the partial frame, this sample opens a new one
            sof_d  = 1'b1;
            peak_d = sample_or;
            cnt_d  = CW'(1);
          end else if (cnt_q == CW'(FRAME_LEN - 1)) begin
            close_d    = 1'b1;
            peak_lat_d = peak_q | sample_or;
            peak_d     = '0;
            cnt_d      = '0;
          end else begin
            sof_d  = (cnt_q == '0);
            peak_d = peak_q | sample_or;
            cnt_d  = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    raw_shift = DIN_WIDTH - 1 - HEADROOM - int'(lead_q);
    if (pzero_q)                   cand = SW'(MAX_SHIFT);
    else if (raw_shift < MIN_SHIFT) cand = '0;
    else if (raw_shift > MAX_SHIFT) cand = SW'(MAX_SHIFT);
    else                           cand = SW'(raw_shift);

    applied_d = applied_q;
    hold_d    = hold_q;
    if (close2_q) begin
      if (cand < applied_q) begin
        applied_d = cand;
        hold_d    = '0;
      end else if (cand == applied_q) begin
        hold_d = '0;
      end else if (int'(hold_q) + 1 >= HOLD_FRAMES) begin
        applied_d = cand;
        hold_d    = '0;
      end else begin
        hold_d = hold_q + HW'(1);
      end
    end
  end

  // Shift is latched on sample 0 so the whole output frame shares one scale
  always_comb begin
    s_cur = sof2_q ? applied_q : fs_lat_q;
    sh_a  = a2_q << s_cur;
    sh_b  = b2_q << s_cur;
    sat_a = (sh_a >> s_cur) != a2_q;
    sat_b = (sh_b >> s_cur) != b2_q;
    out_a = sat_a ? '1 : sh_a;
    out_b = sat_b ? '1 : sh_b;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      peak_q        <= '0;
      peak_lat_q    <= '0;
      close1_q      <= 1'b0;
      close2_q      <= 1'b0;
      lead_q        <= '0;
      pzero_q       <= 1'b0;
      applied_q     <= '0;
      hold_q        <= '0;
      v1_q          <= 1'b0;
      v2_q          <= 1'b0;
      v3_q          <= 1'b0;
      sof1_q        <= 1'b0;
      sof2_q        <= 1'b0;
      sof3_q        <= 1'b0;
      a1_q          <= '0;
      b1_q          <= '0;
      a2_q          <= '0;
      b2_q          <= '0;
      a3_q          <= '0;
      b3_q          <= '0;
      fs_lat_q      <= '0;
      s3_q          <= '0;
      ovf3_q        <= 1'b0;
      dout1_q       <= '0;
      dout2_q       <= '0;
      dout_valid_q  <= 1'b0;
      dout_sof_q    <= 1'b0;
      frame_shift_q <= '0;
      ovf_q         <= '0;
    end else if (ce) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      peak_q     <= peak_d;
      peak_lat_q <= peak_lat_d;
      close1_q   <= close_d;
      close2_q   <= close1_q;
      if (close1_q) begin
        lead_q  <= lead_one(peak_lat_q);
        pzero_q <= (peak_lat_q == '0);
      end
      applied_q <= applied_d;
      hold_q    <= hold_d;

      v1_q   <= accept_d;
      sof1_q <= sof_d;
      if (accept_d) begin
        a1_q <= bus.din1;
        b1_q <= bus.din2;
      end
      v2_q   <= v1_q;
      sof2_q <= v1_q & sof1_q;
      if (v1_q) begin
        a2_q <= a1_q;
        b2_q <= b1_q;
      end
      v3_q   <= v2_q;
      sof3_q <= v2_q & sof2_q;
      if (v2_q) begin
        fs_lat_q <= s_cur;
        a3_q     <= out_a;
        b3_q     <= out_b;
        s3_q     <= s_cur;
        ovf3_q   <= sat_a | sat_b;
      end
      dout_valid_q <= v3_q;
      dout_sof_q   <= v3_q & sof3_q;
      if (v3_q) begin
        dout1_q       <= a3_q;
        dout2_q       <= b3_q;
        frame_shift_q <= s3_q;
        if (ovf3_q && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
      end
    end
  end

  assign bus.dout1       = dout1_q;
  assign bus.dout2       = dout2_q;
  assign bus.dout_valid  = dout_valid_q;
  assign bus.dout_sof    = dout_sof_q;
  assign bus.frame_shift = frame_shift_q;
  assign bus.ovf_count   = ovf_q;

endmodule
